time_display_driver: RTL and testbench

- Display-side consumer of the stopwatch/timer time base: takes a binary centisecond count and converts it to HH:MM:SS.CC decimal digits with a multi-cycle divider.
- Drives an 8-digit multiplexed, active-low seven-segment display with separator dots and optional field blinking for edit mode.
- Sits between the timer core's count output and the board display pins.

---
 rtl/time_display_driver.sv | 227 ++++++++++++++++++++++
 tb/tb_time_display_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/time_display_driver.sv
// Converts a binary centisecond count to HH:MM:SS.CC with a serial restoring divider
// and scans the result onto an 8-digit active-low seven-segment display.
module time_display_driver #(
  parameter int WIDTH     = 32,
  parameter int SCAN_DIV  = 1,
  parameter int BLINK_DIV = 50
) (
  input  logic             clockSignal,
  input  logic             reset,
  input  logic [WIDTH-1:0] timeCount,
  input  logic             loadValid,
  output logic             loadReady,
  output logic             displayValid,
  output logic             overflow,
  input  logic             blinkEnable,
  input  logic [1:0]       blinkField,
  output logic [7:0]       anodeN,
  output logic [6:0]       segmentN,
  output logic             dpN
);

  localparam int RW = WIDTH + 20;
  localparam int DW = WIDTH + 19;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  localparam logic [DW-1:0] DIV_HOURS  = DW'(360000);
  localparam logic [DW-1:0] DIV_MINS   = DW'(6000);
  localparam logic [DW-1:0] DIV_SECS   = DW'(100);
  localparam logic [CW-1:0] LAST_STEP  = CW'(WIDTH - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {IDLE, DIV_H, DIV_M, DIV_S, COMMIT} state_t;

  function automatic logic [7:0] split_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              dv_q, dv_d;
  logic              ovf_q, ovf_d;
  logic [7:0][3:0]   digit_q, digit_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [1:0]        field_q, field_d;

  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [DW-1:0]     rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hours_q, hours_d;
  logic [6:0]        min_q, min_d;

  logic [DW-1:0]     divisor;
  logic [RW-1:0]     trial;
  logic              fits;
  logic [DW-1:0]     rem_next;
  logic [WIDTH-1:0]  quo_next;
  logic [6:0]        fh, fm, fs, fc;
  logic              blank;
  logic [3:0]        lit_digit;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    case (state_q)
      DIV_H:   divisor = DIV_HOURS;
      DIV_M:   divisor = DIV_MINS;
      default: divisor = DIV_SECS;
    endcase
    trial    = {rem_q, dvd_q[WIDTH-1]};
    fits     = trial >= RW'(divisor);
    rem_next = fits ? DW'(trial - RW'(divisor)) : trial[DW-1:0];
    quo_next = {dvd_q[WIDTH-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    dv_d    = dv_q;
    ovf_d   = ovf_q;
    digit_d = digit_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    hours_d = hours_q;
    min_d   = min_q;
    fh      = hours_q[6:0];
    fm      = min_q;
    fs      = dvd_q[6:0];
    fc      = rem_q[6:0];
    case (state_q)
      IDLE: begin
        if (loadValid && ready_q) begin
          dvd_d   = timeCount;
          rem_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = DIV_H;
        end else begin
          ready_d = 1'b1;
        end
      end
      DIV_H, DIV_M, DIV_S: begin
        rem_d = rem_next;
        dvd_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          cnt_d = '0;
          // Hand the remainder on as the next stage's dividend; DIV_S keeps sec/cs in place.
          if (state_q == DIV_H) begin
            hours_d = quo_next;
            dvd_d   = rem_next[WIDTH-1:0];
            rem_d   = '0;
            state_d = DIV_M;
          end else if (state_q == DIV_M) begin
            min_d   = quo_next[6:0];
            dvd_d   = rem_next[WIDTH-1:0];
            rem_d   = '0;
            state_d = DIV_S;
          end else begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (RW'(hours_q) > RW'(99)) begin
          fh    = 7'd99;
          fm    = 7'd59;
          fs    = 7'd59;
          fc    = 7'd99;
          ovf_d = 1'b1;
        end else begin
          ovf_d = 1'b0;
        end
        digit_d = {split_bcd(fh), split_bcd(fm), split_bcd(fs), split_bcd(fc)};
        dv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    field_d     = blinkField;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q - 3'd1;
    end
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clockSignal) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      dv_q        <= 1'b0;
      ovf_q       <= 1'b0;
      digit_q     <= '0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      field_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      dv_q        <= dv_d;
      ovf_q       <= ovf_d;
      digit_q     <= digit_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      field_q     <= field_d;
    end
  end

  // Divider datapath is always (re)loaded on accept, so it needs no reset.
  always_ff @(posedge clockSignal) begin
    dvd_q   <= dvd_d;
    rem_q   <= rem_d;
    cnt_q   <= cnt_d;
    hours_q <= hours_d;
    min_q   <= min_d;
  end

  // Field f owns digits 7-2f and 6-2f, i.e. idx[2:1] == 3-f.
  always_comb begin
    lit_digit = digit_q[idx_q];
    blank     = blinkEnable && phase_q && (idx_q[2:1] == (2'd3 - field_q));
    anodeN    = dv_q ? ~(8'b1 << idx_q) : 8'hFF;
    segmentN  = (dv_q && !blank) ? seg_encode(lit_digit) : 7'h7F;
    dpN       = !(dv_q && !blank && !idx_q[0] && (idx_q != 3'd0));
  end

  assign loadReady    = ready_q;
  assign displayValid = dv_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Checks time_display_driver against an arithmetic model of the time split,
// scan position and blink phase, observing every displayed cycle.
module tb_time_display_driver;

  localparam int W  = 32;
  localparam int BD = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] timeCount = '0;
  logic         loadValid = 1'b0;
  logic         blinkEnable = 1'b0;
  logic [1:0]   blinkField = 2'd0;
  logic         loadReady, displayValid, overflow, dpN;
  logic [7:0]   anodeN;
  logic [6:0]   segmentN;

  int   total = 0;
  int   bad = 0;
  int   n = 0;
  int   field_seen = 0;
  bit   mon_en = 1'b0;
  logic exp_dv = 1'b0;
  logic exp_ovf = 1'b0;
  int   exp_dig [8];
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  time_display_driver #(.WIDTH(W), .SCAN_DIV(1), .BLINK_DIV(BD)) dut (
    .clockSignal (clk),
    .reset       (reset),
    .timeCount   (timeCount),
    .loadValid   (loadValid),
    .loadReady   (loadReady),
    .displayValid(displayValid),
    .overflow    (overflow),
    .blinkEnable (blinkEnable),
    .blinkField  (blinkField),
    .anodeN      (anodeN),
    .segmentN    (segmentN),
    .dpN         (dpN)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    exp_dv  = 1'b0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 8; i++) exp_dig[i] = 0;
  endtask

  task automatic model_commit(input logic [W-1:0] v);
    longint unsigned h, m, s, c, r;
    h = longint'(v) / 360000;
    r = longint'(v) % 360000;
    m = r / 6000;
    r = r % 6000;
    s = r / 100;
    c = r % 100;
    if (h > 99) begin
      h = 99; m = 59; s = 59; c = 99;
      exp_ovf = 1'b1;
    end else begin
      exp_ovf = 1'b0;
    end
    exp_dig[7] = int'(h / 10); exp_dig[6] = int'(h % 10);
    exp_dig[5] = int'(m / 10); exp_dig[4] = int'(m % 10);
    exp_dig[3] = int'(s / 10); exp_dig[2] = int'(s % 10);
    exp_dig[1] = int'(c / 10); exp_dig[0] = int'(c % 10);
    exp_dv = 1'b1;
  endtask

  // Edges since the last reset edge determine scan position and blink phase.
  always @(posedge clk) begin
    n          <= reset ? 0 : n + 1;
    field_seen <= reset ? 0 : int'(blinkField);
  end

  always @(negedge clk) begin
    int idx;
    logic blank;
    logic [17:0] exp_o;
    if (mon_en) begin
      idx = (8 - (n % 8)) % 8;
      if (!exp_dv) begin
        exp_o = {1'b0, exp_ovf, 8'hFF, 7'h7F, 1'b1};
      end else begin
        blank = blinkEnable && (((n / BD) % 2) == 1) && ((idx / 2) == (3 - field_seen));
        exp_o = {1'b1, exp_ovf, ~(8'd1 << idx),
                 blank ? 7'h7F : seg_tab[exp_dig[idx]],
                 (!blank && (idx == 6 || idx == 4 || idx == 2)) ? 1'b0 : 1'b1};
      end
      chk("outputs", {14'd0, displayValid, overflow, anodeN, segmentN, dpN}, {14'd0, exp_o});
    end
  end

  task automatic do_load(input logic [W-1:0] v, input int extra_at, input logic [W-1:0] extra_v);
    chk("ready_idle", {31'd0, loadReady}, 32'd1);
    timeCount = v;
    loadValid = 1'b1;
    tick;
    loadValid = 1'b0;
    timeCount = $urandom;
    chk("ready_drop", {31'd0, loadReady}, 32'd0);
    for (int i = 0; i < 3 * W; i++) begin
      if (i == extra_at) begin
        loadValid = 1'b1;
        timeCount = extra_v;
        chk("ready_busy", {31'd0, loadReady}, 32'd0);
      end else begin
        loadValid = 1'b0;
      end
      tick;
    end
    loadValid = 1'b0;
    tick;
    model_commit(v);
    chk("ready_commit", {31'd0, loadReady}, 32'd0);
    tick;
    chk("ready_back", {31'd0, loadReady}, 32'd1);
  endtask

  initial begin
    model_reset();
    repeat (3) tick;
    chk("rst_anode", {24'd0, anodeN}, 32'hFF);
    chk("rst_seg", {25'd0, segmentN}, 32'h7F);
    chk("rst_dp", {31'd0, dpN}, 32'd1);
    chk("rst_ready", {31'd0, loadReady}, 32'd1);
    chk("rst_dv", {31'd0, displayValid}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (5) tick;

    do_load(32'd0, -1, '0);
    do_load(32'd4523467, -1, '0);
    do_load(32'd36000000, -1, '0);
    do_load(32'd359999, -1, '0);
    do_load(32'd35999999, -1, '0);
    do_load(32'hFFFFFFFF, -1, '0);
    do_load(32'd6000, 9, 32'd100);
    repeat (3) tick;
    chk("no_queue", {31'd0, loadReady}, 32'd1);

    // Abort a conversion with reset partway through.
    timeCount = 32'd4523467;
    loadValid = 1'b1;
    tick;
    loadValid = 1'b0;
    repeat (39) tick;
    reset = 1'b1;
    tick;
    model_reset();
    chk("abort_ready", {31'd0, loadReady}, 32'd1);
    chk("abort_dv", {31'd0, displayValid}, 32'd0);
    chk("abort_anode", {24'd0, anodeN}, 32'hFF);
    reset = 1'b0;
    repeat (2) tick;
    do_load(32'd123456, -1, '0);

    for (int k = 0; k < 10; k++) begin
      logic [W-1:0] v;
      v = (k % 3 == 0) ? W'($urandom) : W'($urandom_range(0, 36000000));
      do_load(v, -1, '0);
      repeat ($urandom_range(0, 9)) tick;
    end

    do_load(32'd4523467, -1, '0);
    blinkEnable = 1'b1;
    blinkField  = 2'd1;
    repeat (24) tick;
    for (int k = 0; k < 6; k++) begin
      blinkField = 2'($urandom_range(0, 3));
      repeat (12) tick;
    end
    blinkEnable = 1'b0;
    repeat (10) tick;

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
